ram_fifo: RTL
=============

RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, pointer width; DEPTH = 2**ADDR_WIDTH words (default 32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write request for the current cycle.
REQ-006 SHALL have port wr_data  input  DATA_WIDTH  word to enqueue.
REQ-007 SHALL have port rd_en  input  1  read request for the current cycle.
REQ-008 SHALL have port rd_data  output  DATA_WIDTH  registered dequeued word.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse marking rd_data as new.
REQ-010 SHALL have port empty  output  1  high when count == 0.
REQ-011 SHALL have port full  output  1  high when count == DEPTH.
REQ-012 SHALL have port count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a write was rejected.
REQ-014 SHALL have port underflow  output  1  sticky: a read was rejected.

Function
REQ-015 SHALL store words in a DEPTH x DATA_WIDTH array addressed by ADDR_WIDTH-bit write and read pointers.
REQ-016 SHALL accept a write when wr_en=1 and (full=0 or a read is accepted the same cycle); accepted write stores wr_data at wr_ptr, wr_ptr increments.
REQ-017 SHALL accept a read when rd_en=1 and empty=0; accepted read loads mem[rd_ptr] into rd_data at that edge, rd_ptr increments, rd_valid=1 for the following cycle.
REQ-018 SHALL hold rd_data unchanged and drive rd_valid=0 in any cycle following no accepted read.
REQ-019 SHALL wrap both pointers modulo DEPTH (DEPTH-1 -> 0) without affecting data order.
REQ-020 SHALL update count: +1 write only, -1 read only, unchanged when both or neither accepted.
REQ-021 SHALL, when full and wr_en=rd_en=1, accept both; count stays DEPTH; the read returns the oldest word, not wr_data.
REQ-022 SHALL, when empty and wr_en=rd_en=1, accept only the write; count becomes 1; underflow sets.
REQ-023 SHALL set overflow on any rejected write and leave memory, wr_ptr and count unchanged.
REQ-024 SHALL set underflow on any rejected read and leave rd_data, rd_ptr and count unchanged.
REQ-025 SHALL keep overflow and underflow set until reset.
REQ-026 SHALL derive empty, full and count from registered state only (no combinational path from wr_en/rd_en).
REQ-027 SHALL give one-cycle read latency: rd_en sampled at edge N -> rd_data/rd_valid valid after edge N.

Reset
REQ-028 SHALL, with reset=1 at a rising edge, clear wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow, underflow to 0 and set empty=1, full=0.
REQ-029 SHALL give reset priority over wr_en/rd_en in the same cycle; in-flight requests are discarded.
REQ-030 SHALL NOT require memory contents to be cleared; stale words are unreachable after reset.

Verification
REQ-031 Reset mid-operation with 5 words stored -> next cycle count=0, empty=1, rd_valid=0, flags 0; subsequent read sets underflow.
REQ-032 Write 4'h1, 4'h2, 4'h3, then three reads -> rd_data 1, 2, 3 each one cycle after rd_en with rd_valid pulses; empty=1 at end.
REQ-033 Write 32 words 0..31 (mod 16) -> full=1, count=32; 33rd write -> overflow=1, count=32; 32 reads return original sequence.
REQ-034 Read when empty with rd_data=4'h3 -> underflow=1, rd_data stays 4'h3, rd_valid=0, count=0.
REQ-035 At full, wr_en=rd_en=1 with wr_data=4'hA -> count stays 32, rd_data = oldest word, 4'hA read back as last of the next 32 reads.
REQ-036 Stream 40 writes interleaved with reads keeping count<=3 -> pointers wrap past 31, all data returned in order, no flags set.

Source files
------------

// File: rtl/ram_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_if
//  Description : Write/read handshake and status bundle for ram_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_fifo_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, empty, full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, empty, full, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/ram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo
//  Description : Synchronous RAM-backed FIFO with registered read port,
//                occupancy count and sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  wire logic     clk,
  input  wire logic     reset,
  ram_fifo_if.slave     bus
);

  localparam int                  c_DEPTH_INT = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH     = c_DEPTH_INT[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH_INT-1];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_DEPTH);
  assign w_rd_acc = bus.rd_en & ~w_empty;
  // A simultaneous read frees a slot, so a write is still taken when full.
  assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
      if (bus.wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_en && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule
`default_nettype wire
